// File: rtl/sim_ctrl.sv
// Simulation controller: holds the DUT in reset, runs it, and decides pass/fail
// from halt, error, timeout and stall conditions, with counters for cycles and commits.
module sim_ctrl #(
  parameter int unsigned CHANNELS     = 8,
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned DRAIN_CYCLES = 5,
  parameter int unsigned STALL_LIMIT  = 10000,
  parameter int unsigned CNT_W        = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CNT_W-1:0]    timeout_cycles,
  input  logic [CHANNELS-1:0] commit,
  input  logic [CHANNELS-1:0] halt,
  input  logic                mon_error,
  input  logic                mem_error,
  output logic                dut_rst,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic [2:0]          fail_cause,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    commit_count
);

  localparam int unsigned PW = $clog2(CHANNELS + 1);
  localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [RW-1:0]    RST_LAST   = RW'(RST_CYCLES - 1);
  localparam logic [DW-1:0]    DRAIN_LAST = DW'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
  localparam logic [SW-1:0]    STALL_LAST = SW'((STALL_LIMIT == 0) ? 0 : STALL_LIMIT - 1);
  localparam logic [CNT_W-1:0] TMO_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [RW-1:0]    r_rst_cnt;
  logic [DW-1:0]    r_drain_cnt;
  logic [SW-1:0]    r_stall;
  logic [CNT_W-1:0] r_tmo;
  logic [CNT_W-1:0] r_cycles;
  logic [CNT_W-1:0] r_commits;
  logic [2:0]       r_cause_pend;
  logic [2:0]       r_cause;
  logic             r_pass;
  logic             r_fail;

  logic [PW-1:0]    w_pop;
  logic [CNT_W:0]   w_sum;
  logic             w_tmo_hit;
  logic             w_stall_hit;
  logic             w_end_pass;
  logic             w_end_fail;
  logic [2:0]       w_end_cause;
  logic [2:0]       w_err_cause;

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) w_pop = w_pop + PW'(commit[i]);
  end

  // One extra bit catches the carry so the commit total can saturate instead of wrapping.
  assign w_sum       = {1'b0, r_commits} + {{(CNT_W + 1 - PW){1'b0}}, w_pop};
  assign w_tmo_hit   = (r_tmo == TMO_ONE);
  assign w_stall_hit = (STALL_LIMIT != 0) && (commit == '0) && (r_stall == STALL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_HOLD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_end_pass  = 1'b0;
    w_end_fail  = 1'b0;
    w_end_cause = '0;
    w_err_cause = '0;
    case (r_state)
      S_HOLD: if (r_rst_cnt == RST_LAST) w_state_nxt = S_RUN;
      S_RUN: begin
        if (mon_error)      w_err_cause = 3'd1;
        else if (mem_error) w_err_cause = 3'd2;
        else if (|halt) begin
          w_end_pass  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_tmo_hit) begin
          w_end_fail  = 1'b1;
          w_end_cause = 3'd3;
          w_state_nxt = S_DONE;
        end else if (w_stall_hit) begin
          w_end_fail  = 1'b1;
          w_end_cause = 3'd4;
          w_state_nxt = S_DONE;
        end
        if (w_err_cause != '0) begin
          if (DRAIN_CYCLES == 0) begin
            w_end_fail  = 1'b1;
            w_end_cause = w_err_cause;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: if (r_drain_cnt == DRAIN_LAST) begin
        w_end_fail  = 1'b1;
        w_end_cause = r_cause_pend;
        w_state_nxt = S_DONE;
      end
      S_DONE: ;
      default: w_state_nxt = S_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_cnt    <= '0;
      r_drain_cnt  <= '0;
      r_stall      <= '0;
      r_tmo        <= '0;
      r_cycles     <= '0;
      r_commits    <= '0;
      r_cause_pend <= '0;
      r_cause      <= '0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_rst_cnt == RST_LAST) r_tmo <= timeout_cycles;
          else                       r_rst_cnt <= r_rst_cnt + RW'(1);
        end
        S_RUN: begin
          if (!(&r_cycles)) r_cycles <= r_cycles + CNT_W'(1);
          r_commits <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
          if (commit != '0)
            r_stall <= '0;
          else if ((STALL_LIMIT != 0) && (r_stall != STALL_LAST))
            r_stall <= r_stall + SW'(1);
          // A zero budget never reaches 1, which is what disables the timeout.
          if (r_tmo != '0) r_tmo <= r_tmo - CNT_W'(1);
          r_cause_pend <= w_err_cause;
          r_drain_cnt  <= '0;
        end
        S_DRAIN: if (r_drain_cnt != DRAIN_LAST) r_drain_cnt <= r_drain_cnt + DW'(1);
        default: ;
      endcase
      if (w_end_pass) r_pass <= 1'b1;
      if (w_end_fail) begin
        r_fail  <= 1'b1;
        r_cause <= w_end_cause;
      end
    end
  end

  assign dut_rst      = (r_state == S_HOLD);
  assign pass         = r_pass;
  assign fail         = r_fail;
  assign done         = r_pass | r_fail;
  assign fail_cause   = r_cause;
  assign cycle_count  = r_cycles;
  assign commit_count = r_commits;

endmodule

// File: tb/tb_sim_ctrl.sv
// Scoreboard bench for sim_ctrl: each run's outcome is predicted from the rules
// and queued; a monitor pops it when done rises and checks it while done holds.
module tb_sim_ctrl;

  localparam int CH   = 8;
  localparam int RST  = 2;
  localparam int DRN  = 5;
  localparam int STL  = 16;
  localparam int CW   = 12;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] timeout_cycles = '0;
  logic [CH-1:0] commit = '0;
  logic [CH-1:0] halt = '0;
  logic          mon_error = 1'b0;
  logic          mem_error = 1'b0;
  logic          dut_rst, done, pass, fail;
  logic [2:0]    fail_cause;
  logic [CW-1:0] cycle_count, commit_count;

  sim_ctrl #(
    .CHANNELS(CH), .RST_CYCLES(RST), .DRAIN_CYCLES(DRN), .STALL_LIMIT(STL), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .timeout_cycles(timeout_cycles), .commit(commit),
    .halt(halt), .mon_error(mon_error), .mem_error(mem_error), .dut_rst(dut_rst),
    .done(done), .pass(pass), .fail(fail), .fail_cause(fail_cause),
    .cycle_count(cycle_count), .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int       done_at;
    bit       pass;
    bit       fail;
    int       cause;
    int       cycles;
    int       commits;
  } exp_t;

  exp_t          sb[$];
  logic [CH-1:0] s_commit[$];
  logic [CH-1:0] s_halt[$];
  bit            s_mon[$];
  bit            s_mem[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_dut_rst"}, 64'(dut_rst), 64'd1);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_fail"}, 64'(fail), 64'd0);
    chk({tag, "_cause"}, 64'(fail_cause), 64'd0);
    chk({tag, "_cycles"}, 64'(cycle_count), 64'd0);
    chk({tag, "_commits"}, 64'(commit_count), 64'd0);
  endtask

  // Reference: walk the run cycle by cycle from the rule list; returns the ending RUN cycle.
  function automatic int model(input int t, output exp_t e);
    int commits = 0;
    int zeros = 0;
    bit ended;
    e = '{default: 0};
    for (int k = 1; k <= s_commit.size(); k++) begin
      commits += $countones(s_commit[k-1]);
      if (commits > CMAX) commits = CMAX;
      zeros = (s_commit[k-1] == '0) ? zeros + 1 : 0;
      ended = 1'b1;
      e.fail = 1'b1;
      e.done_at = k;
      if (s_mon[k-1])                begin e.cause = 1; e.done_at = k + DRN; end
      else if (s_mem[k-1])           begin e.cause = 2; e.done_at = k + DRN; end
      else if (s_halt[k-1] != '0)    begin e.pass = 1'b1; e.fail = 1'b0; end
      else if (t != 0 && k == t)     e.cause = 3;
      else if (zeros == STL)         e.cause = 4;
      else                           ended = 1'b0;
      if (ended) begin
        e.cycles  = (k > CMAX) ? CMAX : k;
        e.commits = commits;
        return k;
      end
    end
    return 0;
  endfunction

  task automatic clear_stim();
    s_commit.delete(); s_halt.delete(); s_mon.delete(); s_mem.delete();
  endtask

  task automatic push_cyc(input logic [CH-1:0] c, input logic [CH-1:0] h, input bit m, input bit e);
    s_commit.push_back(c); s_halt.push_back(h); s_mon.push_back(m); s_mem.push_back(e);
  endtask

  task automatic drive(input int idx);
    if (idx < s_commit.size()) begin
      commit = s_commit[idx]; halt = s_halt[idx];
      mon_error = s_mon[idx]; mem_error = s_mem[idx];
    end else begin
      commit = CH'($urandom); halt = CH'($urandom);
      mon_error = 1'($urandom); mem_error = 1'($urandom);
    end
  endtask

  task automatic do_run(input int t, input int abort_k);
    exp_t e;
    int   end_k, total;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("reset");
    @(negedge clk);
    drive(-1 + 1 << 20);
    timeout_cycles = CW'(t);
    rst_n = 1'b1;
    end_k = model(t, e);
    if (abort_k == 0) begin
      e.done_at += cyc + RST;
      sb.push_back(e);
    end
    for (int i = 1; i <= RST; i++) begin
      @(negedge clk);
      chk("dut_rst_release", 64'(dut_rst), (i < RST) ? 64'd1 : 64'd0);
      if (i < RST) drive(1 << 20);
    end
    timeout_cycles = CW'($urandom);
    total = (abort_k != 0) ? abort_k : end_k + DRN + 4;
    for (int k = 1; k <= total; k++) begin
      if (k > 1) @(negedge clk);
      drive(k - 1);
    end
    @(negedge clk);
    if (abort_k != 0) begin
      #2 rst_n = 1'b0;
      #1 check_reset("midrun_reset");
    end else begin
      #1 chk("done_seen", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  // Monitor: invariants every cycle, and the scoreboard entry once done rises.
  bit   active = 1'b0;
  bit   stray = 1'b0;
  exp_t cur;
  initial forever begin
    @(negedge clk);
    if (dut_rst === 1'b1) begin
      active = 1'b0;
      stray  = 1'b0;
    end else begin
      chk("pass_fail_excl", 64'(pass & fail), 64'd0);
      chk("done_eq_pass_or_fail", 64'(done), 64'(pass | fail));
      if (done === 1'b1 && !active && !stray) begin
        if (sb.size() == 0) begin
          n_vec++; n_bad++; stray = 1'b1;
          $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
        end else begin
          cur = sb.pop_front();
          active = 1'b1;
          chk("done_cycle", 64'(cyc), 64'(cur.done_at));
        end
      end
      if (active) begin
        chk("done_hold", 64'(done), 64'd1);
        chk("pass", 64'(pass), 64'(cur.pass));
        chk("fail", 64'(fail), 64'(cur.fail));
        chk("fail_cause", 64'(fail_cause), 64'(cur.cause));
        chk("cycle_count", 64'(cycle_count), 64'(cur.cycles));
        chk("commit_count", 64'(commit_count), 64'(cur.commits));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int zp, len, t;
    repeat (2) @(negedge clk);

    // halt[3] on the 10th RUN cycle
    clear_stim();
    for (int k = 1; k <= 10; k++) push_cyc(CH'($urandom_range(1, 255)), (k == 10) ? 8'h08 : 8'h00, 0, 0);
    do_run(0, 0);

    // timeout of 100 with steady commits
    clear_stim();
    for (int k = 1; k <= 120; k++) push_cyc(8'h01, (k == 120) ? 8'h01 : 8'h00, 0, 0);
    do_run(100, 0);

    // mon_error together with halt[0]: error wins, then drain
    clear_stim();
    for (int k = 1; k <= 7; k++) push_cyc(CH'($urandom_range(1, 255)), (k == 7) ? 8'h01 : 8'h00, k == 7, 0);
    do_run(0, 0);

    // commits stop after 20 cycles: stall on the 16th idle cycle
    clear_stim();
    for (int k = 1; k <= 60; k++) push_cyc((k <= 20) ? 8'h5A : 8'h00, (k == 60) ? 8'h02 : 8'h00, 0, 0);
    do_run(0, 0);

    // commit sum 8+8+8+1
    clear_stim();
    push_cyc(8'hFF, 0, 0, 0); push_cyc(8'hFF, 0, 0, 0); push_cyc(8'hFF, 0, 0, 0);
    push_cyc(8'h01, 0, 0, 0); push_cyc(8'h00, 8'h80, 0, 0);
    do_run(0, 0);

    // mem_error with halt, then mon+mem together, then timeout of 1
    clear_stim();
    for (int k = 1; k <= 3; k++) push_cyc(8'h11, (k == 3) ? 8'h40 : 8'h00, 0, k == 3);
    do_run(0, 0);
    clear_stim();
    for (int k = 1; k <= 4; k++) push_cyc(8'h03, (k == 4) ? 8'h10 : 8'h00, k == 4, k == 4);
    do_run(0, 0);
    clear_stim();
    for (int k = 1; k <= 5; k++) push_cyc(8'h03, (k == 5) ? 8'h10 : 8'h00, 0, 0);
    do_run(1, 0);

    // reset mid-RUN, then a fresh run
    clear_stim();
    for (int k = 1; k <= 50; k++) push_cyc(8'h0F, (k == 50) ? 8'h01 : 8'h00, 0, 0);
    do_run(0, 20);
    do_run(0, 0);

    // both counters saturate
    clear_stim();
    for (int k = 1; k <= 4200; k++) push_cyc(8'hFF, (k == 4200) ? 8'h20 : 8'h00, 0, 0);
    do_run(0, 0);

    for (int r = 0; r < 40; r++) begin
      clear_stim();
      len = $urandom_range(5, 80);
      zp  = ($urandom_range(0, 1) == 0) ? 10 : 85;
      for (int k = 1; k <= len; k++)
        push_cyc(($urandom_range(0, 99) < zp) ? 8'h00 : CH'($urandom_range(1, 255)),
                 (k == len || $urandom_range(0, 99) < 3) ? CH'(1 << $urandom_range(0, CH - 1)) : 8'h00,
                 $urandom_range(0, 199) < 3, $urandom_range(0, 199) < 3);
      t = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 70);
      do_run(t, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
